// File: rtl/flush_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flush_controller                                           |
// | Description : Pipeline flush sequencer. A down-counter (nop_cnt) walks a |
// |               squash wave from the earliest stage to writeback after a   |
// |               taken branch or an interrupt request.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CLK            in   sole clock, rising edge                             |
// |   RESET_N        in   synchronous active-low reset                        |
// |   UNCON_BRN      in   unconditional branch resolved this cycle            |
// |   TAKE_COND_BRN  in   conditional branch resolved taken this cycle        |
// |   STALL          in   pipeline hold, freezes flush progress               |
// |   INTR           in   interrupt flush request (level)                     |
// |   STAGE_NOP      out  per-stage squash, bit 0 earliest, MSB writeback     |
// |   FLUSH_BUSY     out  high while the FSM is not IDLE                      |
// |   INTR_ACK       out  one-cycle pulse after an interrupt flush completes  |
// +--------------------------------------------------------------------------+
// | Build option                                                             |
// |   FLUSH_CTRL_INTR_EN : when defined, the interrupt flush path is built;   |
// |                        otherwise INTR is ignored and INTR_ACK is 0.       |
// +--------------------------------------------------------------------------+
module flush_controller #(
  parameter int N_STAGES    = 4,
  parameter int BRN_PENALTY = 4,
  parameter int CNT_W       = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                UNCON_BRN,
  input  logic                TAKE_COND_BRN,
  input  logic                STALL,
  input  logic                INTR,
  output logic [N_STAGES-1:0] STAGE_NOP,
  output logic                FLUSH_BUSY,
  output logic                INTR_ACK
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BRN_FLUSH = 2'd1,
    ST_INT_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_BRN_LOAD = CNT_W'(BRN_PENALTY);
  localparam logic [CNT_W-1:0] C_INT_LOAD = CNT_W'(N_STAGES);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO     = '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_nop_cnt;
  logic [CNT_W-1:0] w_nop_cnt_nxt;
  logic             w_brn;
  logic             w_brn_accept;
  logic             w_intr_load;

  assign w_brn = UNCON_BRN | TAKE_COND_BRN;

  // A new branch may only start once the previous wave has all but left the
  // pipe (count <= 1); younger branches are themselves being squashed.
  assign w_brn_accept = w_brn & ~STALL & (r_nop_cnt <= C_ONE) &
                        (r_state != ST_INT_FLUSH);

`ifdef FLUSH_CTRL_INTR_EN
  logic w_int_done;
  logic r_int_done;
  logic r_intr_ack;

  // Interrupt load ignores STALL: the pipeline must be emptied regardless.
  assign w_intr_load = INTR & (r_state != ST_INT_FLUSH);

  // Nothing can preempt INT_FLUSH, so the final decrement is exactly this.
  assign w_int_done  = (r_state == ST_INT_FLUSH) & ~STALL & (r_nop_cnt == C_ONE);

  // Two-stage delay places the acknowledge one cycle after the counter
  // has settled at zero.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_int_done <= 1'b0;
      r_intr_ack <= 1'b0;
    end else begin
      r_int_done <= w_int_done;
      r_intr_ack <= r_int_done;
    end
  end

  assign INTR_ACK = r_intr_ack;
`else
  // INTR is kept on the port list but has no effect in this build.
  assign w_intr_load = INTR & 1'b0;
  assign INTR_ACK    = 1'b0;
`endif

  // Priority: interrupt load, branch load, stall hold, decrement.
  always_comb begin
    w_nop_cnt_nxt = r_nop_cnt;
    w_state_nxt   = r_state;
    if (w_intr_load) begin
      w_nop_cnt_nxt = C_INT_LOAD;
      w_state_nxt   = ST_INT_FLUSH;
    end else if (w_brn_accept) begin
      w_nop_cnt_nxt = C_BRN_LOAD;
      w_state_nxt   = ST_BRN_FLUSH;
    end else if (!STALL && (r_nop_cnt != C_ZERO)) begin
      w_nop_cnt_nxt = r_nop_cnt - C_ONE;
      if (r_nop_cnt == C_ONE) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_nop_cnt <= C_ZERO;
      r_state   <= ST_IDLE;
    end else begin
      r_nop_cnt <= w_nop_cnt_nxt;
      r_state   <= w_state_nxt;
    end
  end

  // Stage i is squashed while the wave has not yet passed it; the earliest
  // stage is also squashed in the very cycle a branch is accepted.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage_nop
    localparam logic [CNT_W-1:0] C_THR = CNT_W'(N_STAGES - 1 - i);
    if (i == 0) begin : g_first
      assign STAGE_NOP[i] = (r_nop_cnt > C_THR) | w_brn_accept;
    end else begin : g_rest
      assign STAGE_NOP[i] = (r_nop_cnt > C_THR);
    end
  end

  assign FLUSH_BUSY = (r_state != ST_IDLE);

endmodule
`default_nettype wire
